// File: rtl/cpu_pkg.sv
// Shared definitions for the M-extension multiply/divide engine.
package cpu_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [2:0] {
    F3Mul    = 3'b000,
    F3Mulh   = 3'b001,
    F3Mulhsu = 3'b010,
    F3Mulhu  = 3'b011,
    F3Div    = 3'b100,
    F3Divu   = 3'b101,
    F3Rem    = 3'b110,
    F3Remu   = 3'b111
  } m_func3_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  function automatic logic is_signed_a(logic [2:0] f3);
    return !(f3 == F3Mulhu || f3 == F3Divu || f3 == F3Remu);
  endfunction

  function automatic logic is_signed_b(logic [2:0] f3);
    return f3 == F3Mul || f3 == F3Mulh || f3 == F3Div || f3 == F3Rem;
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift in the next dividend bit, trial subtract the divisor.
module muldiv_divstep #(
  parameter int unsigned Xlen = 32
) (
  input  logic [Xlen-1:0] rem_i,
  input  logic            bit_i,
  input  logic [Xlen-1:0] divisor_i,
  output logic [Xlen-1:0] rem_o,
  output logic            qbit_o
);

  logic [Xlen:0]   shifted;
  logic [Xlen-1:0] diff;

  // Partial remainder can reach Xlen+1 bits after the shift, so compare at full width.
  assign shifted = {rem_i, bit_i};
  assign diff    = shifted[Xlen-1:0] - divisor_i;
  assign qbit_o  = shifted >= {1'b0, divisor_i};
  assign rem_o   = qbit_o ? diff : shifted[Xlen-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide engine; works on magnitudes, applies sign in FIX.
module muldiv_unit
  import cpu_pkg::*;
#(
  parameter int unsigned Xlen            = XlenDefault,
  parameter int unsigned MulBitsPerCycle = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      func3_i,
  input  logic [Xlen-1:0] op_a_i,
  input  logic [Xlen-1:0] op_b_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [Xlen-1:0] result_o
);

  localparam int unsigned Mb       = MulBitsPerCycle;
  localparam int unsigned MulIters = Xlen / Mb;
  localparam int unsigned CntW     = (Xlen > 1) ? $clog2(Xlen) : 1;

  md_state_e         state_q, state_d;
  logic [2:0]        func3_q, func3_d;
  logic [Xlen-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*Xlen-1:0] acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q, neg_d;

  logic            sign_a, sign_b, launch, div_zero, div_ovf, div_qbit;
  logic [Xlen-1:0] abs_a, abs_b, div_rem, div_sel, fix_result;
  logic [Xlen+Mb-1:0] mul_pp, mul_hi;
  logic [2*Xlen-1:0]  prod_fix;

  assign sign_a   = is_signed_a(func3_i) & op_a_i[Xlen-1];
  assign sign_b   = is_signed_b(func3_i) & op_b_i[Xlen-1];
  assign abs_a    = sign_a ? -op_a_i : op_a_i;
  assign abs_b    = sign_b ? -op_b_i : op_b_i;
  assign div_zero = op_b_i == '0;
  assign div_ovf  = !func3_i[0] && op_a_i == {1'b1, {(Xlen-1){1'b0}}} && op_b_i == '1;

  assign mul_pp = {{Mb{1'b0}}, a_q} * {{Xlen{1'b0}}, b_q[Mb-1:0]};
  assign mul_hi = {{Mb{1'b0}}, acc_q[2*Xlen-1:Xlen]} + mul_pp;

  muldiv_divstep #(.Xlen(Xlen)) u_divstep (
    .rem_i    (acc_q[2*Xlen-1:Xlen]),
    .bit_i    (acc_q[Xlen-1]),
    .divisor_i(b_q),
    .rem_o    (div_rem),
    .qbit_o   (div_qbit)
  );

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign div_sel  = func3_q[1] ? acc_q[2*Xlen-1:Xlen] : acc_q[Xlen-1:0];

  always_comb begin
    fix_result = '0;
    if (!func3_q[2]) begin
      fix_result = (func3_q[1:0] == 2'b00) ? prod_fix[Xlen-1:0] : prod_fix[2*Xlen-1:Xlen];
    end else begin
      fix_result = neg_q ? -div_sel : div_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    launch   = 1'b0;
    unique case (state_q)
      StIdle: launch = start_i;
      StMul: begin
        acc_d = (2*Xlen)'({mul_hi, acc_q[Xlen-1:0]} >> Mb);
        b_d   = b_q >> Mb;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(MulIters - 1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = {div_rem, acc_q[Xlen-2:0], div_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(Xlen - 1)) state_d = StFix;
      end
      StFix: begin
        result_d = fix_result;
        state_d  = StDone;
      end
      StDone: begin
        if (!hold_i) begin
          state_d = StIdle;
          launch  = start_i && !flush_i;
        end
      end
      default: state_d = StIdle;
    endcase

    if (launch) begin
      func3_d = func3_i;
      a_d     = abs_a;
      b_d     = abs_b;
      cnt_d   = '0;
      acc_d   = '0;
      // Remainder takes the dividend's sign; everything else the product of signs.
      neg_d   = (func3_i[2] && func3_i[1]) ? sign_a : (sign_a ^ sign_b);
      if (!func3_i[2]) begin
        state_d = StMul;
      end else if (div_zero) begin
        acc_d   = {op_a_i, {Xlen{1'b1}}};
        neg_d   = 1'b0;
        state_d = StFix;
      end else if (div_ovf) begin
        acc_d   = {{Xlen{1'b0}}, op_a_i};
        neg_d   = 1'b0;
        state_d = StFix;
      end else begin
        acc_d   = {{Xlen{1'b0}}, abs_a};
        state_d = StDiv;
      end
    end

    if (flush_i && state_q != StIdle) state_d = StIdle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      func3_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = state_q == StMul || state_q == StDiv || state_q == StFix;
  assign done_o   = state_q == StDone;
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latencies, flush, reset and hold.
module tb_muldiv_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.Xlen(32), .MulBitsPerCycle(8)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .func3_i (func3),
    .op_a_i  (op_a),
    .op_b_i  (op_b),
    .flush_i (flush),
    .hold_i  (hold),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the START-sampling edge.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    func3 = f3;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges (START edge = 1) until DONE, bounded.
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 1;
    busy_cycles = 0;
    while (!done && edges < 100) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int e, bc;
    launch(f3, a, b);
    wait_done(e, bc);
    check({tag, "_lat"}, e, exp_lat);
    check({tag, "_res"}, result, exp);
  endtask

  initial begin
    int e, bc;
    logic seen;

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(F3Mul, 32'd7, 32'hFFFF_FFFD);
    wait_done(e, bc);
    check("mul_lat", e, 6);
    check("mul_res", result, 32'hFFFF_FFEB);
    check("mul_busy_cycles", bc, 5);
    @(negedge clk);
    check("mul_done_drop", done, 1'b0);
    check("mul_busy_after", busy, 1'b0);

    run("mulh",   F3Mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 6);
    run("mulhu",  F3Mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6);
    run("mulhsu", F3Mulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 6);

    run("divu", F3Divu, 32'd100,        32'd7, 32'd14,        34);
    run("remu", F3Remu, 32'd100,        32'd7, 32'd2,         34);
    run("rem",  F3Rem,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF, 34);
    run("div",  F3Div,  32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD, 34);

    run("div_by0", F3Div, 32'd5,          32'd0,         32'hFFFF_FFFF, 2);
    run("rem_by0", F3Rem, 32'd5,          32'd0,         32'd5,         2);
    run("rem_ovf", F3Rem, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2);
    run("div_ovf", F3Div, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2);

    // Flush mid-division
    launch(F3Divu, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_done", done, 1'b0);
    check("flush_result_kept", result, 32'h8000_0000);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_no_done", seen, 1'b0);
    run("mul_after_flush", F3Mul, 32'd3, 32'd4, 32'd12, 6);

    // Reset mid-division
    launch(F3Divu, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", seen, 1'b0);

    // Hold at completion; START while held must be ignored
    hold = 1'b1;
    run("hold_mul", F3Mul, 32'd3, 32'd4, 32'd12, 6);
    func3 = F3Mul;
    op_a  = 32'd5;
    op_b  = 32'd5;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("hold_done", done, 1'b1);
      check("hold_result", result, 32'd12);
      @(negedge clk);
    end
    check("hold_done_c4", done, 1'b1);
    check("hold_result_c4", result, 32'd12);
    hold = 1'b0;
    launch(F3Mul, 32'd6, 32'd7);
    wait_done(e, bc);
    check("b2b_lat", e, 6);
    check("b2b_res", result, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide engine implementing the RV32IM M-extension ops for the EX stage of the 5-stage pipeline.
- Multiply is computed in MUL_BITS_PER_CYCLE-bit radix steps; divide is restoring, one bit per cycle.
- While an op is in flight the unit asserts BUSY, which stalls IF/ID/EX the same way MEM_BUSYWAIT does.
- XLEN and multiply throughput are parametrised so the same block serves RV32 now and RV64 later.

Parameters:
- XLEN, 32, operand/result width.
- MUL_BITS_PER_CYCLE, 8, multiplier bits consumed per iteration. Must divide XLEN. Value XLEN gives a single-iteration multiply.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  launch op. Sampled only in IDLE.
- FUNC3  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OP_A  in  XLEN  rs1 value (multiplicand/dividend).
- OP_B  in  XLEN  rs2 value (multiplier/divisor).
- FLUSH  in  1  abort in-flight op (branch flush from flush_unit).
- HOLD  in  1  downstream stall (MEM_BUSYWAIT); keeps result presented.
- BUSY  out  1  op in flight; pipeline must stall.
- DONE  out  1  RESULT valid.
- RESULT  out  XLEN  op result.

Behaviour:
- Reset (RESET=0, async): state=IDLE; BUSY=0, DONE=0, RESULT=0; iteration counter, accumulators and sign flags cleared. Reset mid-operation discards the op; no DONE is produced.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - START=1 latches FUNC3, latches |OP_A| and |OP_B| per signedness, and records the result sign.
  - Signed ops: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats only A as signed. MULHU/DIVU/REMU treat both as unsigned.
  - Next state: MUL for funct3[2]=0; FIX directly for the division special cases; otherwise DIV.
  - BUSY=1 from the cycle after the START edge until DONE.
- MUL: XLEN/MUL_BITS_PER_CYCLE iterations. Each iteration adds the partial product of the low MUL_BITS_PER_CYCLE multiplier bits into a 2*XLEN accumulator, then shifts. After the last iteration, go to FIX.
- DIV: XLEN iterations of restoring division on a 2*XLEN remainder/quotient register, then FIX.
- FIX:
  - Conditionally two's-complement the product, quotient or remainder.
  - Select the result: low half for MUL, high half for MULH*, quotient for DIV*, remainder for REM*.
  - Register RESULT and go to DONE.
- Division special cases, resolved at START with no iterations:
  - divisor=0: quotient=all-ones, remainder=OP_A.
  - Signed overflow (OP_A=most-negative, OP_B=-1): quotient=OP_A, remainder=0.
- DONE:
  - DONE=1, BUSY=0.
  - HOLD=1: remain in DONE; RESULT stable.
  - HOLD=0: return to IDLE next edge, DONE=0.
  - A START seen in DONE with HOLD=0 is accepted as a new op (back-to-back).
- Latency, in edges from the START-sampling edge to DONE=1:
  - MUL*: XLEN/MUL_BITS_PER_CYCLE+2 (6 at default).
  - DIV*/REM*: XLEN+2 (34).
  - Special cases: 2.
- START while in MUL/DIV/FIX is ignored.
- FLUSH=1 in any non-IDLE state returns to IDLE next edge with BUSY=0 and DONE=0. FLUSH has priority over HOLD and START. RESULT keeps its last value.
- All arithmetic is unsigned on magnitudes. Sign is applied only in FIX. No overflow flags are output.

Decomposition:
- Shared package cpu_pkg:
  - FUNC3 encodings for the M ops (MUL..REMU).
  - State enum for IDLE/MUL/DIV/FIX/DONE.
  - XLEN default.
- One natural sub-module: muldiv_divstep, a combinational single restoring-division step (trial subtract, quotient bit, next remainder), instantiated once in the DIV datapath.
- The multiply step stays inline.

Test Plan:
- MUL, OP_A=7, OP_B=0xFFFFFFFD -> DONE after 6 edges, RESULT=0xFFFFFFEB; BUSY high for exactly 5 cycles.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIVU 100/7 -> DONE after 34 edges, RESULT=14. REMU -> 2. REM 0xFFFFFFF9/2 -> 0xFFFFFFFF. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
- DIV 5/0 -> 0xFFFFFFFF in 2 edges. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0.
- DIV in progress, FLUSH pulsed at iteration 10 -> IDLE next edge, no DONE. Next START of MUL 3×4 -> 12 in 6 edges. Repeat with RESET=0 at iteration 10 -> all outputs 0 immediately.
- HOLD=1 for 3 cycles at completion of MUL 3×4 -> DONE and RESULT=12 stable 4 cycles. START during those cycles is ignored. START at the first HOLD=0 cycle launches the next op.
